alu_seq: RTL and testbench

- Parametrised, registered successor to the team's combinational datapath ALU.
- Accepts one operation per transaction over a valid/ready handshake and returns a registered result with a full flag set.
- Adds an iterative multi-cycle multiply, variable shifts and signed compares.
- Sits between the instruction decode stage and writeback, where it absorbs back-pressure from writeback.

---
 rtl/alu_pkg.sv | 51 +++++
 rtl/alu_mul_iter.sv | 50 +++++
 rtl/alu_seq.sv | 156 +++++++++++++++
 tb/tb_alu_seq.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states and the
// flag computation used by both the single-cycle and multiply result paths.
package alu_pkg;

  // Widest operand the flag helper has to handle.
  localparam int MAX_W = 64;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLTU = 4'd8;
  localparam logic [3:0] OP_SLT  = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic zero;
    logic neg;
    logic carry;
    logic ovf;
    logic err;
  } flags_t;

  // Result is passed zero-extended to MAX_W; msb selects the sign bit of the
  // real operand width. carry is only meaningful for ADD/SUB, ovf for
  // ADD/SUB/MUL; every opcode above OP_MUL is illegal.
  function automatic flags_t calc_flags(input logic [3:0]       op,
                                        input logic [MAX_W-1:0] res,
                                        input logic [5:0]       msb,
                                        input logic             carry,
                                        input logic             ovf);
    flags_t f;
    f.zero  = (res == '0);
    f.neg   = res[msb];
    f.carry = ((op == OP_ADD) || (op == OP_SUB)) && carry;
    f.ovf   = ((op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL)) && ovf;
    f.err   = (op > OP_MUL);
    return f;
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier. A start pulse loads the operands;
// one partial product is added per cycle for WIDTH cycles. done is high
// during the final iteration, so product is complete on the following cycle.
module alu_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;

  assign busy    = (cnt != '0);
  assign done    = busy && (cnt == CW'(1));
  assign product = acc;

  // Load on start, otherwise add-and-shift one multiplier bit per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (start) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
      cnt    <= CW'(WIDTH);
    end else if (busy) begin
      if (mplier[0]) begin
        acc <= acc + mcand;
      end
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with a valid/ready front and back end. Single-cycle ops
// write the output register on the edge after acceptance; MUL runs through
// the iterative multiplier and lands WIDTH+1 edges after acceptance.
//
// Handshake: a transfer happens on any edge where valid && ready is high.
// The producer holds its payload until then; the output register holds
// result and flags stable while out_valid && !out_ready. in_ready depends
// combinationally on out_ready only, never on in_valid.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             ovf,
  output logic             err,
  output state_t           dbg_state
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [5:0] MSB = 6'(WIDTH - 1);

  state_t             state;
  flags_t             flags_q;
  logic               accept;
  logic               mul_start;
  logic               mul_busy;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  logic [WIDTH:0]     sum_ext;
  logic [WIDTH:0]     diff_ext;
  logic [SHW-1:0]     shamt;
  logic [WIDTH-1:0]   alu_r;
  logic               alu_c;
  logic               alu_v;
  logic [MAX_W-1:0]   alu_r_ext;
  logic [MAX_W-1:0]   mul_r_ext;
  flags_t             alu_f;
  flags_t             mul_f;

  assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (op == OP_MUL);

  assign zero      = flags_q.zero;
  assign neg       = flags_q.neg;
  assign carry     = flags_q.carry;
  assign ovf       = flags_q.ovf;
  assign err       = flags_q.err;
  assign dbg_state = state;

  alu_mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

  // Single-cycle datapath: result plus raw carry/overflow for the current op.
  always_comb begin
    sum_ext  = {1'b0, a} + {1'b0, b};
    diff_ext = {1'b0, a} - {1'b0, b};
    shamt    = b[SHW-1:0];
    alu_r    = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    case (op)
      OP_ADD: begin
        alu_r = sum_ext[WIDTH-1:0];
        alu_c = sum_ext[WIDTH];
        alu_v = (a[WIDTH-1] == b[WIDTH-1]) && (alu_r[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_r = diff_ext[WIDTH-1:0];
        alu_c = diff_ext[WIDTH];
        alu_v = (a[WIDTH-1] != b[WIDTH-1]) && (alu_r[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  alu_r = a & b;
      OP_OR:   alu_r = a | b;
      OP_XOR:  alu_r = a ^ b;
      OP_SLL:  alu_r = a << shamt;
      OP_SRL:  alu_r = a >> shamt;
      OP_SRA:  alu_r = $signed(a) >>> shamt;
      OP_SLTU: alu_r[0] = (a < b);
      OP_SLT:  alu_r[0] = ($signed(a) < $signed(b));
      default: alu_r = '0;
    endcase
    alu_r_ext = '0;
    alu_r_ext[WIDTH-1:0] = alu_r;
    alu_f = calc_flags(op, alu_r_ext, MSB, alu_c, alu_v);
  end

  // Multiply result path: low half is the result, a nonzero high half is ovf.
  always_comb begin
    mul_r_ext = '0;
    mul_r_ext[WIDTH-1:0] = mul_prod[WIDTH-1:0];
    mul_f = calc_flags(OP_MUL, mul_r_ext, MSB, 1'b0, |mul_prod[2*WIDTH-1:WIDTH]);
  end

  // Control FSM and output register; a new result load wins over retiring.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      flags_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && (op != OP_MUL)) begin
            out_valid <= 1'b1;
            result    <= alu_r;
            flags_q   <= alu_f;
          end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
          end
          if (mul_start) begin
            state <= MUL;
          end
        end
        MUL: begin
          if (mul_busy && mul_done) begin
            state <= DONE;
          end
        end
        DONE: begin
          out_valid <= 1'b1;
          result    <= mul_prod[WIDTH-1:0];
          flags_q   <= mul_f;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq at WIDTH=8: directed cases followed by randomized
// traffic with random back-pressure, checked against an arithmetic model.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         neg;
  logic         carry;
  logic         ovf;
  logic         err;
  state_t       dbg_state;

  int           n_cmp;
  int           n_bad;
  bit           mon_en;
  bit           rand_rdy;
  logic [12:0]  exp_q[$];
  logic [12:0]  exp_item;
  bit           hold_prev;
  logic [13:0]  hold_snap;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .neg       (neg),
    .carry     (carry),
    .ovf       (ovf),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: packed {result[7:0], zero, neg, carry, ovf, err}.
  function automatic logic [12:0] ref_model(input int o, input int x, input int y);
    int sa, sb, r, sh, s;
    bit c, v, e;
    sa = (x > 127) ? x - 256 : x;
    sb = (y > 127) ? y - 256 : y;
    sh = y % 8;
    c = 0; v = 0; e = 0; r = 0;
    case (o)
      0:  begin r = x + y; c = (r > 255); s = sa + sb; v = (s > 127) || (s < -128); end
      1:  begin r = x - y; c = (x < y);   s = sa - sb; v = (s > 127) || (s < -128); end
      2:  r = x & y;
      3:  r = x | y;
      4:  r = x ^ y;
      5:  r = x << sh;
      6:  r = x >> sh;
      7:  r = sa >>> sh;
      8:  r = (x < y) ? 1 : 0;
      9:  r = (sa < sb) ? 1 : 0;
      10: begin r = x * y; v = (r > 255); end
      default: begin r = 0; e = 1; end
    endcase
    r = r & 255;
    return {r[7:0], (r == 0), (r > 127), c, v, e};
  endfunction

  // ---------------- driver ----------------
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
    bit done;
    int waited;
    in_valid = 1'b1; op = o; a = x; b = y;
    done = 0; waited = 0;
    while (!done && waited < 200) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(ref_model(o, x, y));
        done = 1;
      end
      waited++;
      @(posedge clk); #1;
    end
    check("send_accept", done, 1);
    in_valid = 1'b0;
    op = 4'($urandom_range(0, 15));
    a = 8'($urandom);
    b = 8'($urandom);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (hold_prev) check("hold_stable", {out_valid, result, zero, neg, carry, ovf, err}, hold_snap);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", exp_q.size(), 1);
        end else begin
          exp_item = exp_q.pop_front();
          check("out", {result, zero, neg, carry, ovf, err}, exp_item);
        end
      end
      hold_prev = out_valid && !out_ready;
      hold_snap = {1'b1, result, zero, neg, carry, ovf, err};
    end else begin
      hold_prev = 0;
    end
  end

  // Random back-pressure while enabled.
  always @(posedge clk) begin
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 9) < 7);
  end

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    n_cmp = 0; n_bad = 0;
    mon_en = 0; rand_rdy = 0; hold_prev = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; a = '0; b = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_result", {result, zero, neg, carry, ovf, err}, 13'h0);
    check("rst_state", dbg_state, IDLE);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", in_ready, 1);
    mon_en = 1; out_ready = 1'b1;

    // ADD wraps with carry
    send(OP_ADD, 8'hFF, 8'h01);
    check("add_ff_01", {out_valid, result, zero, carry, ovf, neg}, {1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0});
    // SUB signed overflow, SLT / SLTU on the same operands
    send(OP_SUB, 8'h80, 8'h01);
    check("sub_80_01", {result, ovf, carry}, {8'h7F, 1'b1, 1'b0});
    send(OP_SLT, 8'h80, 8'h01);
    check("slt_80_01", result, 8'h01);
    send(OP_SLTU, 8'h80, 8'h01);
    check("sltu_80_01", result, 8'h00);
    idle_cycles(2);

    // MUL latency and result
    send(OP_MUL, 8'd13, 8'd11);
    cyc = 0;
    while (cyc < 50) begin
      @(negedge clk);
      if (out_valid) break;
      check("mul_in_ready_low", in_ready, 0);
      cyc++;
    end
    check("mul_latency", cyc, 9);
    check("mul_13x11", {result, ovf}, {8'h8F, 1'b0});
    @(posedge clk); #1;
    send(OP_MUL, 8'h10, 8'h10);
    cyc = 0;
    while (!out_valid && cyc < 50) begin @(negedge clk); cyc++; end
    check("mul_10x10", {result, zero, ovf}, {8'h00, 1'b1, 1'b1});
    @(posedge clk); #1;
    idle_cycles(2);

    // Back-pressure then simultaneous retire + accept
    out_ready = 1'b0;
    send(OP_ADD, 8'd3, 8'd4);
    repeat (5) begin
      @(negedge clk);
      check("bp_hold", {out_valid, result, in_ready}, {1'b1, 8'h07, 1'b0});
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(OP_XOR, 8'hF0, 8'h0F);
    check("xor_no_bubble", {out_valid, result, neg}, {1'b1, 8'hFF, 1'b1});

    // Shift amount masking and illegal op
    send(OP_SRA, 8'h90, 8'h12);
    check("sra_90_12", result, 8'hE4);
    send(4'd12, 8'h5A, 8'hA5);
    check("illegal_12", {result, err, zero}, {8'h00, 1'b1, 1'b1});
    idle_cycles(3);

    // Asynchronous reset in the middle of a multiply
    send(OP_MUL, 8'($urandom), 8'($urandom));
    idle_cycles(3);
    mon_en = 0;
    rst = 1'b1;
    #1;
    check("rst_mid_mul_valid", out_valid, 0);
    check("rst_mid_mul_state", dbg_state, IDLE);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("rst_release_ready", in_ready, 1);
    mon_en = 1;
    send(OP_ADD, 8'h21, 8'h12);
    check("add_after_rst", {out_valid, result}, {1'b1, 8'h33});

    // Randomized traffic with random back-pressure
    rand_rdy = 1;
    for (int i = 0; i < 300; i++) begin
      idle_cycles($urandom_range(0, 2));
      send(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
    end
    @(posedge clk); #1;
    rand_rdy = 0;
    out_ready = 1'b1;
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge clk);
    @(posedge clk); #1;
    check("drain_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
